// File: rtl/cdb_arbiter.sv
// Result-broadcast arbiter: per-source result FIFOs feeding CDB_W registered CDB lanes, round-robin.
// Optional macro CDB_ARB_BYPASS_EN lets an empty source's live input compete directly (1-edge latency).
module cdb_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int CDB_W      = 2,
    parameter int PHYS_W     = 6,
    parameter int ROB_W      = 6,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           flush,
    input  logic [NUM_SRC-1:0]             fu_valid,
    output logic [NUM_SRC-1:0]             fu_ready,
    input  logic [NUM_SRC-1:0][PHYS_W-1:0] fu_tag,
    input  logic [NUM_SRC-1:0][DATA_W-1:0] fu_value,
    input  logic [NUM_SRC-1:0][ROB_W-1:0]  fu_rob_tag,
    output logic [CDB_W-1:0]               cdb_valid,
    output logic [CDB_W-1:0][PHYS_W-1:0]   cdb_tag,
    output logic [CDB_W-1:0][DATA_W-1:0]   cdb_value,
    output logic [CDB_W-1:0][ROB_W-1:0]    cdb_rob_tag,
    output logic [15:0]                    stall_cnt
);
    localparam int ENTRY_W = PHYS_W + ROB_W + DATA_W;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [ENTRY_W-1:0] mem [NUM_SRC][FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr [NUM_SRC];
    logic [PTR_W-1:0]   wr_ptr [NUM_SRC];
    logic [CNT_W-1:0]   count  [NUM_SRC];

    logic [SRC_W-1:0]   rr_ptr, rr_next, last_src, scan_idx;
    logic [NUM_SRC-1:0] cand, grant, push, pop;
    logic [NUM_SRC-1:0][ENTRY_W-1:0] cand_entry;
    logic [CDB_W-1:0]   lane_valid;
    logic [CDB_W-1:0][ENTRY_W-1:0]   lane_entry;
    logic               stall;
    int                 n_grant;

    always_comb begin
        fu_ready   = '0;
        cand       = '0;
        cand_entry = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            fu_ready[s] = (count[s] < CNT_W'(FIFO_DEPTH));
`ifdef CDB_ARB_BYPASS_EN
            // An empty source competes with its live input fields.
            cand[s]       = (count[s] != '0) || fu_valid[s];
            cand_entry[s] = (count[s] != '0) ? mem[s][rd_ptr[s]]
                                             : {fu_tag[s], fu_rob_tag[s], fu_value[s]};
`else
            cand[s]       = (count[s] != '0);
            cand_entry[s] = mem[s][rd_ptr[s]];
`endif
        end
    end

    always_comb begin
        grant      = '0;
        lane_valid = '0;
        lane_entry = '0;
        n_grant    = 0;
        last_src   = rr_ptr;
        scan_idx   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            scan_idx = SRC_W'((int'(rr_ptr) + i) % NUM_SRC);
            if (cand[scan_idx] && (n_grant < CDB_W)) begin
                grant[scan_idx]     = 1'b1;
                lane_valid[n_grant] = 1'b1;
                lane_entry[n_grant] = cand_entry[scan_idx];
                n_grant             = n_grant + 1;
                last_src            = scan_idx;
            end
        end
        stall = |(cand & ~grant);
        if (grant == '0)
            rr_next = rr_ptr;
        else if (last_src == SRC_W'(NUM_SRC - 1))
            rr_next = '0;
        else
            rr_next = last_src + 1'b1;
    end

    always_comb begin
        push = '0;
        pop  = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            pop[s]  = grant[s] && (count[s] != '0);
`ifdef CDB_ARB_BYPASS_EN
            push[s] = fu_valid[s] && fu_ready[s] && !(grant[s] && (count[s] == '0));
`else
            push[s] = fu_valid[s] && fu_ready[s];
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                count[s]  <= '0;
                rd_ptr[s] <= '0;
                wr_ptr[s] <= '0;
            end
        end else if (flush) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                count[s]  <= '0;
                rd_ptr[s] <= '0;
                wr_ptr[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (push[s]) wr_ptr[s] <= wr_ptr[s] + 1'b1;
                if (pop[s])  rd_ptr[s] <= rd_ptr[s] + 1'b1;
                if (push[s] && !pop[s])
                    count[s] <= count[s] + 1'b1;
                else if (pop[s] && !push[s])
                    count[s] <= count[s] - 1'b1;
            end
        end
    end

    // Storage needs no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_SRC; s++) begin
            if (push[s] && !flush)
                mem[s][wr_ptr[s]] <= {fu_tag[s], fu_rob_tag[s], fu_value[s]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cdb_valid   <= '0;
            cdb_tag     <= '0;
            cdb_value   <= '0;
            cdb_rob_tag <= '0;
            rr_ptr      <= '0;
            stall_cnt   <= '0;
        end else if (flush) begin
            cdb_valid   <= '0;
            cdb_tag     <= '0;
            cdb_value   <= '0;
            cdb_rob_tag <= '0;
        end else begin
            cdb_valid <= lane_valid;
            for (int l = 0; l < CDB_W; l++)
                {cdb_tag[l], cdb_rob_tag[l], cdb_value[l]} <= lane_entry[l];
            rr_ptr <= rr_next;
            if (stall && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_cdb_arbiter;
    localparam int NS    = 4;
    localparam int CW    = 2;
    localparam int DEPTH = 2;
`ifdef CDB_ARB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic [5:0]  tag;
        logic [5:0]  rob;
        logic [63:0] val;
    } entry_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic flush = 1'b0;
    logic [NS-1:0] fu_valid = '0;
    logic [NS-1:0] fu_ready;
    logic [NS-1:0][5:0]  fu_tag = '0;
    logic [NS-1:0][63:0] fu_value = '0;
    logic [NS-1:0][5:0]  fu_rob_tag = '0;
    logic [CW-1:0] cdb_valid;
    logic [CW-1:0][5:0]  cdb_tag;
    logic [CW-1:0][63:0] cdb_value;
    logic [CW-1:0][5:0]  cdb_rob_tag;
    logic [15:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .fu_valid(fu_valid), .fu_ready(fu_ready),
        .fu_tag(fu_tag), .fu_value(fu_value), .fu_rob_tag(fu_rob_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_rob_tag(cdb_rob_tag), .stall_cnt(stall_cnt)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic entry_t mkEntry(input int s);
        return {fu_tag[s], fu_rob_tag[s], fu_value[s]};
    endfunction

    // Reference model: one queue per source, round-robin pick of the first CW candidates.
    entry_t mq [NS][$];
    int     m_gr [$];
    bit     m_room [NS];
    bit     m_byp [NS];
    bit     m_cnd;
    int     m_rr = 0;
    int     m_stall = 0;
    int     m_ncand;
    int     m_s;
    logic [CW-1:0] e_valid = '0;
    entry_t e_lane [CW] = '{default: '0};

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NS; k++) mq[k].delete();
            m_rr = 0;
            m_stall = 0;
            e_valid = '0;
            for (int l = 0; l < CW; l++) e_lane[l] = '0;
        end else if (flush) begin
            for (int k = 0; k < NS; k++) mq[k].delete();
            e_valid = '0;
            for (int l = 0; l < CW; l++) e_lane[l] = '0;
        end else begin
            m_gr.delete();
            m_ncand = 0;
            for (int k = 0; k < NS; k++) begin
                m_room[k] = mq[k].size() < DEPTH;
                m_byp[k] = 1'b0;
            end
            for (int i = 0; i < NS; i++) begin
                m_s = (m_rr + i) % NS;
                m_cnd = mq[m_s].size() > 0;
`ifdef CDB_ARB_BYPASS_EN
                m_cnd = m_cnd || (fu_valid[m_s] === 1'b1);
`endif
                if (m_cnd) begin
                    m_ncand++;
                    if (m_gr.size() < CW) m_gr.push_back(m_s);
                end
            end
            e_valid = '0;
            for (int l = 0; l < CW; l++) e_lane[l] = '0;
            for (int l = 0; l < m_gr.size(); l++) begin
                m_s = m_gr[l];
                e_valid[l] = 1'b1;
                if (mq[m_s].size() > 0) begin
                    e_lane[l] = mq[m_s].pop_front();
                end else begin
                    e_lane[l] = mkEntry(m_s);
                    m_byp[m_s] = 1'b1;
                end
            end
            if (m_ncand > m_gr.size() && m_stall < 65535) m_stall++;
            if (m_gr.size() > 0) m_rr = (m_gr[m_gr.size()-1] + 1) % NS;
            for (int k = 0; k < NS; k++)
                if (fu_valid[k] && m_room[k] && !m_byp[k]) mq[k].push_back(mkEntry(k));
        end
    end

    always @(negedge clk) begin
        logic [NS-1:0] exp_ready;
        for (int k = 0; k < NS; k++) exp_ready[k] = mq[k].size() < DEPTH;
        checkOutput("cdb_valid", cdb_valid, e_valid);
        for (int l = 0; l < CW; l++) begin
            checkOutput($sformatf("cdb_tag%0d", l), cdb_tag[l], e_lane[l].tag);
            checkOutput($sformatf("cdb_rob%0d", l), cdb_rob_tag[l], e_lane[l].rob);
            checkOutput($sformatf("cdb_value%0d", l), cdb_value[l], e_lane[l].val);
        end
        checkOutput("fu_ready", fu_ready, exp_ready);
        checkOutput("stall_cnt", stall_cnt, m_stall);
    end

    // Streaming monitor: per-source order and grant fairness.
    bit mon_en = 0;
    int mon_cyc = 0;
    int order_err = 0;
    int next_seq [NS] = '{default: 0};
    int gnt_cnt [NS] = '{default: 0};
    bit saw_low [NS] = '{default: 0};
    int mon_s;

    always @(negedge clk) begin
        if (mon_en) begin
            for (int l = 0; l < CW; l++) begin
                if (cdb_valid[l]) begin
                    mon_s = int'(cdb_rob_tag[l][1:0]);
                    if (int'(cdb_value[l][31:0]) != next_seq[mon_s]) order_err++;
                    next_seq[mon_s]++;
                    if (mon_cyc >= 10 && mon_cyc < 26) gnt_cnt[mon_s]++;
                end
            end
            for (int k = 0; k < NS; k++) if (!fu_ready[k]) saw_low[k] = 1'b1;
            mon_cyc++;
        end
    end

    int seq [NS] = '{default: 0};
    logic [NS-1:0] rdy_prev = '0;

    task automatic applyStimulus(input logic [NS-1:0] valid, input logic fl);
        @(negedge clk);
        #1;
        fu_valid = valid;
        flush = fl;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Every source offers continuously, holding data until accepted.
    task automatic streamStep(input logic fl);
        @(negedge clk);
        #1;
        for (int k = 0; k < NS; k++) begin
            if (fu_valid[k] && rdy_prev[k]) seq[k]++;
            fu_tag[k] = 6'(seq[k]);
            fu_rob_tag[k] = 6'(k);
            fu_value[k] = {32'(k), 32'(seq[k])};
        end
        fu_valid = '1;
        flush = fl;
        rdy_prev = fu_ready;
    endtask

    initial begin
        bit seen;
        waitCycles(2);
        reset_n = 1'b1;
        waitCycles(1);
        checkOutput("reset_valid", cdb_valid, 2'b00);
        checkOutput("reset_ready", fu_ready, 4'hF);
        checkOutput("reset_stall", stall_cnt, 16'd0);

        // All four sources at once, rr_ptr=0.
        for (int k = 0; k < NS; k++) begin
            fu_tag[k] = 6'(10 + k);
            fu_value[k] = 64'h100 + 64'(k);
            fu_rob_tag[k] = 6'(20 + k);
        end
        fu_valid = 4'hF;
        applyStimulus(4'h0, 1'b0);
        waitCycles(LAT - 1);
        checkOutput("all4_A_valid", cdb_valid, 2'b11);
        checkOutput("all4_A_lane0", cdb_tag[0], 6'd10);
        checkOutput("all4_A_lane1", cdb_tag[1], 6'd11);
        checkOutput("all4_A_val1", cdb_value[1], 64'h101);
        checkOutput("all4_A_stall", stall_cnt, 16'd1);
        waitCycles(1);
        checkOutput("all4_B_valid", cdb_valid, 2'b11);
        checkOutput("all4_B_lane0", cdb_tag[0], 6'd12);
        checkOutput("all4_B_lane1", cdb_rob_tag[1], 6'd23);
        checkOutput("all4_B_stall", stall_cnt, 16'd1);
        waitCycles(1);
        checkOutput("all4_idle_valid", cdb_valid, 2'b00);

        // Single result from source 1.
        fu_tag[1] = 6'd5;
        fu_value[1] = 64'hABCD;
        fu_rob_tag[1] = 6'd3;
        fu_valid = 4'b0010;
        applyStimulus(4'h0, 1'b0);
        waitCycles(LAT - 1);
        checkOutput("single_valid", cdb_valid, 2'b01);
        checkOutput("single_tag", cdb_tag[0], 6'd5);
        checkOutput("single_value", cdb_value[0], 64'hABCD);
        checkOutput("single_rob", cdb_rob_tag[0], 6'd3);
        checkOutput("single_lane1_value", cdb_value[1], 64'h0);

        // Continuous traffic: backpressure, ordering and fairness.
        mon_en = 1'b1;
        repeat (30) streamStep(1'b0);
        mon_en = 1'b0;
        streamStep(1'b1);
        applyStimulus(4'h0, 1'b0);
        checkOutput("flush_valid", cdb_valid, 2'b00);
        checkOutput("flush_ready", fu_ready, 4'hF);
        for (int c = 0; c < 4; c++) begin
            waitCycles(1);
            checkOutput("post_flush_valid", cdb_valid, 2'b00);
        end
        checkOutput("stream_order", order_err, 0);
        for (int k = 0; k < NS; k++) begin
            checkOutput($sformatf("fair_src%0d", k), gnt_cnt[k], 8);
            checkOutput($sformatf("progress_src%0d", k), next_seq[k] >= 8, 1'b1);
        end
        checkOutput("src2_ready_dropped", saw_low[2], 1'b1);

        // Asynchronous reset while both lanes are busy.
        rdy_prev = '0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            streamStep(1'b0);
            if (cdb_valid == 2'b11) seen = 1'b1;
        end
        checkOutput("pre_reset_valid", cdb_valid, 2'b11);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", cdb_valid, 2'b00);
        checkOutput("async_reset_stall", stall_cnt, 16'd0);
        checkOutput("async_reset_ready", fu_ready, 4'hF);
        checkOutput("async_reset_tag", cdb_tag[0], 6'd0);
        fu_valid = '0;
        waitCycles(2);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            waitCycles(1);
            checkOutput("post_reset_valid", cdb_valid, 2'b00);
            checkOutput("post_reset_stall", stall_cnt, 16'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
